// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: takes a payload word over valid/ready and shifts out
// sync word, payload (MSB first) and idle gap bits on a single registered line.
module serial_frame_tx #(
  parameter int unsigned      LEN    = 4,
  parameter logic [LEN-1:0]   STD    = 4'b1101,
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      GAP    = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              dat_out,
  output logic              sync_flag,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_GAP
  } state_t;

  localparam logic [7:0] SYNC_LAST = 8'(LEN - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_W - 1);
  localparam logic [7:0] GAP_LAST  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_t              state;
  state_t              state_nx;
  logic [7:0]          cnt;
  logic [7:0]          cnt_nx;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_nx;
  logic [LEN-1:0]      sync_word;
  logic                dat_d;
  logic                sync_d;
  logic                done_d;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      shreg      <= '0;
      dat_out    <= 1'b0;
      sync_flag  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      dat_out    <= dat_d;
      sync_flag  <= sync_d;
      frame_done <= done_d;
    end
  end

  // The counter clears on every state change, so each phase counts from zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 8'd1;
    shreg_nx = shreg;
    case (state)
      ST_IDLE: begin
        cnt_nx = 8'd0;
        if (tx_valid) begin
          state_nx = ST_SYNC;
          shreg_nx = tx_data;
        end
      end
      ST_SYNC: begin
        if (cnt == SYNC_LAST) begin
          state_nx = ST_DATA;
          cnt_nx   = 8'd0;
        end
      end
      ST_DATA: begin
        shreg_nx = shreg << 1;
        if (cnt == DATA_LAST) begin
          state_nx = (GAP != 0) ? ST_GAP : ST_IDLE;
          cnt_nx   = 8'd0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = 8'd0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Line outputs are decoded from the next state so the registered line lines
  // up with the state: first sync bit appears one cycle after the handshake.
  always_comb begin
    sync_word = STD >> (SYNC_LAST - cnt_nx);
    dat_d     = 1'b0;
    sync_d    = 1'b0;
    done_d    = 1'b0;
    case (state_nx)
      ST_SYNC: begin
        dat_d  = sync_word[0];
        sync_d = 1'b1;
      end
      ST_DATA: begin
        dat_d  = shreg_nx[DATA_W-1];
        done_d = (cnt_nx == DATA_LAST);
      end
      default: begin
        dat_d = 1'b0;
      end
    endcase
  end

  assign tx_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default-parameter instance plus a
// DATA_W=1, GAP=0 corner instance, with a small sync-word detector model.
module tb_serial_frame_tx;

  logic       sys_clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       dat_out;
  logic       sync_flag;
  logic       frame_done;

  logic       tx_valid2;
  logic [0:0] tx_data2;
  logic       tx_ready2;
  logic       dat_out2;
  logic       sync_flag2;
  logic       frame_done2;

  logic [3:0] det_hist;
  logic       det_find;

  int errors;
  int checks;

  serial_frame_tx #(.LEN(4), .STD(4'b1101), .DATA_W(8), .GAP(2)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .dat_out    (dat_out),
    .sync_flag  (sync_flag),
    .frame_done (frame_done)
  );

  serial_frame_tx #(.LEN(4), .STD(4'b1101), .DATA_W(1), .GAP(0)) dut_corner (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .tx_valid   (tx_valid2),
    .tx_data    (tx_data2),
    .tx_ready   (tx_ready2),
    .dat_out    (dat_out2),
    .sync_flag  (sync_flag2),
    .frame_done (frame_done2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference detector: 4-bit window on the line, registered find.
  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      det_hist <= 4'd0;
      det_find <= 1'b0;
    end else begin
      det_hist <= {det_hist[2:0], dat_out};
      det_find <= (det_hist == 4'b1101);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send(input logic [7:0] d);
    @(negedge sys_clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge sys_clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (dat_out !== 1'b0 || sync_flag !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b%b%b exp=000", dat_out, sync_flag, frame_done);
    end
    checks++;
    if (tx_ready !== 1'b1 || tx_ready2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b%b exp=11", tx_ready, tx_ready2);
    end
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({dat_out, tx_ready, sync_flag, frame_done} !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL idle cyc=%0d got=%b exp=0100", k,
                 {dat_out, tx_ready, sync_flag, frame_done});
      end
    end
  endtask

  task automatic test_single_frame;
    logic [13:0] exp_bits;
    exp_bits = 14'b1101_10100101_00;
    send(8'hA5);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) begin
        @(posedge sys_clk);
        #1;
      end
      checks++;
      if (k <= 14 && dat_out !== exp_bits[14-k]) begin
        errors++;
        $display("[TB] FAIL frame_a5_bit cyc=%0d got=%b exp=%b", k, dat_out, exp_bits[14-k]);
      end
      checks++;
      if (sync_flag !== (k <= 4)) begin
        errors++;
        $display("[TB] FAIL frame_a5_sync cyc=%0d got=%b exp=%b", k, sync_flag, (k <= 4));
      end
      checks++;
      if (frame_done !== (k == 12)) begin
        errors++;
        $display("[TB] FAIL frame_a5_done cyc=%0d got=%b exp=%b", k, frame_done, (k == 12));
      end
      checks++;
      if (tx_ready !== (k == 15)) begin
        errors++;
        $display("[TB] FAIL frame_a5_ready cyc=%0d got=%b exp=%b", k, tx_ready, (k == 15));
      end
    end
  endtask

  task automatic test_busy_reject;
    logic [13:0] exp_bits;
    exp_bits = 14'b1101_00111100_00;
    send(8'h3C);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin
        @(posedge sys_clk);
        #1;
      end
      if (k <= 14) begin
        checks++;
        if (dat_out !== exp_bits[14-k] || tx_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_bit cyc=%0d got=%b/%b exp=%b/0", k, dat_out, tx_ready,
                   exp_bits[14-k]);
        end
      end else if (k == 15) begin
        checks++;
        if (tx_ready !== 1'b1 || dat_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_ready15 got=%b/%b exp=1/0", tx_ready, dat_out);
        end
      end else begin
        checks++;
        if (dat_out !== 1'b1 || sync_flag !== 1'b1 || tx_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_accept16 got=%b%b%b exp=110", dat_out, sync_flag, tx_ready);
        end
        tx_valid = 1'b0;
      end
    end
    idle_cycles(14);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_ff_end got=%b exp=1", tx_ready);
    end
  endtask

  task automatic test_loopback;
    idle_cycles(6);
    send(8'h00);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin
        @(posedge sys_clk);
        #1;
      end
      checks++;
      if (det_find !== (k == 6)) begin
        errors++;
        $display("[TB] FAIL loopback_find cyc=%0d got=%b exp=%b", k, det_find, (k == 6));
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [11:0] exp_bits;
    exp_bits = 12'b1101_10000001;
    send(8'hA5);
    idle_cycles(6);
    rst = 1'b0;
    #1;
    checks++;
    if ({dat_out, sync_flag, frame_done, tx_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_async got=%b exp=0001", {dat_out, sync_flag, frame_done, tx_ready});
    end
    for (int j = 1; j <= 3; j++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({dat_out, frame_done, tx_ready} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL midrst_hold j=%0d got=%b exp=001", j, {dat_out, frame_done, tx_ready});
      end
    end
    rst = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({dat_out, frame_done, tx_ready} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL midrst_release j=%0d got=%b exp=001", j, {dat_out, frame_done, tx_ready});
      end
    end
    send(8'h81);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge sys_clk);
        #1;
      end
      checks++;
      if (dat_out !== exp_bits[12-k] || frame_done !== (k == 12)) begin
        errors++;
        $display("[TB] FAIL midrst_frame81 cyc=%0d got=%b/%b exp=%b/%b", k, dat_out, frame_done,
                 exp_bits[12-k], (k == 12));
      end
    end
    idle_cycles(4);
  endtask

  task automatic test_corner;
    logic [4:0] exp_bits;
    exp_bits = 5'b11011;
    @(negedge sys_clk);
    tx_valid2 = 1'b1;
    tx_data2  = 1'b1;
    @(posedge sys_clk);
    #1;
    tx_valid2 = 1'b0;
    tx_data2  = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin
        @(posedge sys_clk);
        #1;
      end
      if (k <= 5) begin
        checks++;
        if (dat_out2 !== exp_bits[5-k]) begin
          errors++;
          $display("[TB] FAIL corner_bit cyc=%0d got=%b exp=%b", k, dat_out2, exp_bits[5-k]);
        end
      end
      checks++;
      if (frame_done2 !== (k == 5)) begin
        errors++;
        $display("[TB] FAIL corner_done cyc=%0d got=%b exp=%b", k, frame_done2, (k == 5));
      end
      checks++;
      if (tx_ready2 !== (k == 6)) begin
        errors++;
        $display("[TB] FAIL corner_ready cyc=%0d got=%b exp=%b", k, tx_ready2, (k == 6));
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2  = 1'b0;
    #2;
    test_reset;
    test_single_frame;
    test_busy_reject;
    test_loopback;
    test_reset_mid_frame;
    test_corner;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
